// File: rtl/serial_shifter_pkg.sv
// Shared control encodings: shamt extender modes, shifter operations and shifter FSM states.
// Also provides the single-bit shift step used by the iterative shifter.
package serial_shifter_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   // Shift-amount extender modes (the extender feeds the shifter's shamt input)
   typedef enum logic [1:0] {
      EXT_ZERO  = 2'b00,
      EXT_SIGN  = 2'b01,
      EXT_IMM5  = 2'b10,
      EXT_RSVD  = 2'b11
   } ext_e;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // An arithmetic right shift never changes bit 31, so the working register's MSB
   // is always the sign bit latched at start.
   function automatic logic [DATA_W-1:0] shift_one(input op_e op_sel, input logic [DATA_W-1:0] value);
      logic [DATA_W-1:0] shifted;
      case (op_sel)
         OP_SLL:  shifted = {value[DATA_W-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, value[DATA_W-1:1]};
         OP_SRA:  shifted = {value[DATA_W-1], value[DATA_W-1:1]};
         default: shifted = value;
      endcase
      return shifted;
   endfunction

endpackage

// File: rtl/serial_shifter.sv
// Iterative one-bit-per-cycle barrel replacement: IDLE -> SHIFT (N cycles) -> DONE pulse.
// Result is only updated on entry to DONE, so it stays stable while a new shift runs.
module serial_shifter
   import serial_shifter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] shamt,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   state_e             state_reg, state_next;
   op_e                op_reg, op_next;
   logic [SHAMT_W-1:0] count_reg, count_next;
   logic [DATA_W-1:0]  work_reg, work_next;
   logic [DATA_W-1:0]  result_reg, result_next;

   op_e                op_in;
   logic [SHAMT_W-1:0] start_count;
   logic [DATA_W-1:0]  shifted;
   logic               unused_shamt_hi;

   assign op_in           = op_e'(op);
   assign unused_shamt_hi = ^shamt[DATA_W-1:SHAMT_W];
   // The reserved op is a pass-through: it takes the zero-length path straight to DONE.
   assign start_count     = (op_in == OP_RSVD) ? '0 : shamt[SHAMT_W-1:0];
   assign shifted         = shift_one(op_reg, work_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         op_reg     <= OP_SLL;
         count_reg  <= '0;
         work_reg   <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         count_reg  <= count_next;
         work_reg   <= work_next;
         result_reg <= result_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      count_next  = count_reg;
      work_next   = work_reg;
      result_next = result_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               op_next    = op_in;
               work_next  = data_in;
               count_next = start_count;
               if (start_count == '0) begin
                  state_next  = ST_DONE;
                  result_next = data_in;
               end else begin
                  state_next = ST_SHIFT;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            work_next  = shifted;
            count_next = count_reg - 1'b1;
            if (count_reg == SHAMT_W'(1)) begin
               state_next  = ST_DONE;
               result_next = shifted;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy   = (state_reg == ST_SHIFT);
   assign done   = (state_reg == ST_DONE);
   assign result = result_reg;

endmodule

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the single clock, all state changes on its rising edge; rst (input, 1) is the synchronous active-high reset.
REQ-002 start  input  1  request to begin a shift; sampled only when idle or in DONE.
REQ-003 op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-004 data_in  input  32  operand to shift; sampled with an accepted start.
REQ-005 shamt  input  32  extended shift amount from the shamt extender; bits [4:0] used, bits [31:5] ignored.
REQ-006 busy  output  1  high while a shift is in progress.
REQ-007 done  output  1  one-cycle pulse, result valid.
REQ-008 result  output  32  shifted value; held stable until the next accepted start.

Function
REQ-009 States SHALL be IDLE, SHIFT and DONE.
REQ-010 An accepted start SHALL latch data_in, op and count = shamt[4:0] in one edge.
- Acceptance: start=1 while the state is IDLE or DONE.
REQ-011 On acceptance, next state SHALL be SHIFT if count != 0; otherwise DONE.
REQ-012 In SHIFT, each cycle SHALL shift the working register one bit and decrement count.
- SLL: shift left, fill 0.
- SRL: shift right, fill 0.
- SRA: shift right, fill the latched bit 31.
REQ-013 SHIFT SHALL go to DONE on the edge where count decrements from 1 to 0.
REQ-014 Latency, with start accepted at edge 0 and N = shamt[4:0]:
- busy=1 during cycles 1..N.
- done=1 during cycle N+1 only.
- N=0 gives done in cycle 1 and busy never high.
REQ-015 result SHALL update to the working register on the edge entering DONE.
- It SHALL hold until the next DONE entry.
- Starting a new shift SHALL NOT change result.
REQ-016 DONE SHALL return to IDLE after one cycle unless start=1, which is accepted (back-to-back).
REQ-017 start SHALL be ignored while in SHIFT; the latched operands and count SHALL be unaffected.
REQ-018 op=11 SHALL behave as N=0: result = data_in, done in cycle 1.
REQ-019 Changes on data_in, op or shamt after acceptance SHALL NOT affect the running shift.
REQ-020 busy and done SHALL never be high in the same cycle.

Reset
REQ-021 While rst=1, all state SHALL clear at the clock edge:
- state=IDLE, busy=0, done=0, result=0x0000_0000, count=0, working register=0.
REQ-022 rst=1 SHALL take priority over start.
REQ-023 A reset during SHIFT SHALL abort the operation, with no done pulse for it.

Structure
REQ-024 The op encodings (SLL/SRL/SRA/reserved) and state encodings SHALL live in the shared control-encoding define file, next to the extender encodings.
REQ-025 The block SHALL be a single module with no sub-modules; the down-counter and working register are inline.

Verification
REQ-026 SLL: data_in=0x0000_0001, shamt=31, start at edge 0 -> busy cycles 1..31; done cycle 32; result=0x8000_0000.
REQ-027 SRA vs SRL, data_in=0x8000_0000, shamt=4:
- SRA -> result=0xF800_0000, done cycle 5.
- SRL -> result=0x0800_0000, done cycle 5.
REQ-028 Zero shift: shamt=0xFFFF_FFE0 (low bits 0), data_in=0x1234_5678, op=SRL -> done cycle 1; busy never high; result=0x1234_5678.
REQ-029 Ignored start: start SLL data_in=0x1, shamt=8, then start=1 with data_in=0xFFFF_FFFF at cycle 3 -> ignored; result=0x0000_0100, done cycle 9.
REQ-030 Back-to-back start in the DONE cycle (SRL 0xF0 by 4) -> accepted; prior result held until new done; new result=0x0000_000F.
REQ-031 Reset mid-shift: rst=1 at cycle 3 of an SLL by 10 -> next cycle busy=0, done=0, result=0, and no done pulse follows.
